// File: rtl/commit_vunit_if.sv
// Signal bundle between the scalar issue stage, the vector lane commit flags and the
// hazard unit commit port. Suffixes are from the commit_vunit (slave) point of view.
interface commit_vunit_if #(
    parameter int NUM_LANE    = 16,
    parameter int WIDTH_ENTRY = 3
);
    logic                            issue_i;
    logic [WIDTH_ENTRY-1:0]          issue_no_i;
    logic [NUM_LANE-1:0]             en_lane_i;
    logic                            full_o;
    logic                            empty_o;
    logic [NUM_LANE-1:0]             commit_lane_i;
    logic [NUM_LANE*WIDTH_ENTRY-1:0] commit_no_i;
    logic                            commit_o;
    logic [WIDTH_ENTRY-1:0]          commit_no_o;
    logic                            error_o;
    logic                            timeout_o;
    logic [WIDTH_ENTRY-1:0]          timeout_no_o;

    modport master (
        output issue_i, issue_no_i, en_lane_i, commit_lane_i, commit_no_i,
        input  full_o, empty_o, commit_o, commit_no_o, error_o, timeout_o, timeout_no_o
    );

    modport slave (
        input  issue_i, issue_no_i, en_lane_i, commit_lane_i, commit_no_i,
        output full_o, empty_o, commit_o, commit_no_o, error_o, timeout_o, timeout_no_o
    );
endinterface

// File: rtl/commit_vunit.sv
// Collects per-lane vector commit flags and retires issue_no values in issue order.
// Optional head-entry watchdog is enabled by defining VCOMMIT_TIMEOUT_EN.
module commit_vunit #(
    parameter int NUM_LANE    = 16,
    parameter int NUM_ENTRY   = 8,
    parameter int WIDTH_ENTRY = $clog2(NUM_ENTRY)
`ifdef VCOMMIT_TIMEOUT_EN
   ,parameter int TIMEOUT     = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst,
    commit_vunit_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_ENTRY + 1);
    localparam int PTR_W = WIDTH_ENTRY + 1;

    typedef logic [WIDTH_ENTRY-1:0] no_t;
    typedef logic [NUM_LANE-1:0]    lane_t;

    logic [NUM_ENTRY-1:0] tab_v_q, tab_v_d;
    lane_t                tab_en_lane_q   [NUM_ENTRY];
    lane_t                tab_en_lane_d   [NUM_ENTRY];
    lane_t                tab_en_commit_q [NUM_ENTRY];
    lane_t                tab_en_commit_d [NUM_ENTRY];
    no_t                  fifo_q          [NUM_ENTRY];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             commit_q, commit_d;
    no_t              commit_no_q, commit_no_d;
    logic             error_q, error_d;

    no_t  head_no;
    no_t  lane_no;
    logic full;
    logic retire;
    logic issue_ok;
    logic issue_err;
    logic commit_err;

    assign head_no   = fifo_q[rd_ptr_q[WIDTH_ENTRY-1:0]];
    assign full      = (count_q == CNT_W'(NUM_ENTRY));
    assign retire    = (count_q != '0) && (tab_en_commit_q[head_no] == tab_en_lane_q[head_no]);
    // Full and valid are judged on pre-edge state; a same-cycle retire never frees a slot.
    assign issue_ok  = bus.issue_i && !full && !tab_v_q[bus.issue_no_i];
    assign issue_err = bus.issue_i && !issue_ok;

    always_comb begin
        // NOTE: every next-state value is defaulted to its current value first, so no latch is inferred.
        tab_v_d         = tab_v_q;
        tab_en_lane_d   = tab_en_lane_q;
        tab_en_commit_d = tab_en_commit_q;
        commit_err      = 1'b0;
        lane_no         = '0;

        for (int i = 0; i < NUM_LANE; i++) begin
            lane_no = bus.commit_no_i[i*WIDTH_ENTRY +: WIDTH_ENTRY];
            if (bus.commit_lane_i[i]) begin
                if (tab_v_q[lane_no] && tab_en_lane_q[lane_no][i] && !tab_en_commit_q[lane_no][i]) begin
                    tab_en_commit_d[lane_no][i] = 1'b1;
                end else begin
                    commit_err = 1'b1;
                end
            end
        end

        // Any commit aimed at the retiring head is already an error, so clearing last is safe.
        if (retire) begin
            tab_v_d[head_no]         = 1'b0;
            tab_en_lane_d[head_no]   = '0;
            tab_en_commit_d[head_no] = '0;
        end

        if (issue_ok) begin
            tab_v_d[bus.issue_no_i]         = 1'b1;
            tab_en_lane_d[bus.issue_no_i]   = bus.en_lane_i;
            tab_en_commit_d[bus.issue_no_i] = '0;
        end
    end

    always_comb begin
        rd_ptr_d    = retire   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d    = issue_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d     = count_q;
        if (issue_ok && !retire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!issue_ok && retire) begin
            count_d = count_q - CNT_W'(1);
        end
        commit_d    = retire;
        commit_no_d = retire ? head_no : commit_no_q;
        error_d     = error_q | issue_err | commit_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            tab_v_q         <= '0;
            tab_en_lane_q   <= '{default: '0};
            tab_en_commit_q <= '{default: '0};
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            commit_q        <= 1'b0;
            commit_no_q     <= '0;
            error_q         <= 1'b0;
        end else begin
            tab_v_q         <= tab_v_d;
            tab_en_lane_q   <= tab_en_lane_d;
            tab_en_commit_q <= tab_en_commit_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            commit_q        <= commit_d;
            commit_no_q     <= commit_no_d;
            error_q         <= error_d;
        end
    end

    // NOTE: the order FIFO payload is only read under count/pointer control, so it needs no reset.
    always_ff @(posedge clk) begin
        if (issue_ok) begin
            fifo_q[wr_ptr_q[WIDTH_ENTRY-1:0]] <= bus.issue_no_i;
        end
    end

    // Pointer distance (wrap bit included) must always equal the occupancy count.
    assert property (@(posedge clk) disable iff (rst) (wr_ptr_q - rd_ptr_q) == PTR_W'(count_q));

    assign bus.full_o      = full;
    assign bus.empty_o     = (count_q == '0);
    assign bus.commit_o    = commit_q;
    assign bus.commit_no_o = commit_no_q;
    assign bus.error_o     = error_q;

`ifdef VCOMMIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    no_t              timeout_no_q, timeout_no_d;

    always_comb begin
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
        timeout_no_d = timeout_no_q;
        if (retire || (count_q == '0)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_W'(TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
                timeout_d    = 1'b1;
                timeout_no_d = head_no;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            timeout_no_q <= '0;
        end else begin
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            timeout_no_q <= timeout_no_d;
        end
    end

    assign bus.timeout_o    = timeout_q;
    assign bus.timeout_no_o = timeout_no_q;
`else
    assign bus.timeout_o    = 1'b0;
    assign bus.timeout_no_o = '0;
`endif
endmodule

// File: tb/tb_commit_vunit.sv
// Self-checking bench for commit_vunit: directed cases plus random issue/commit traffic
// compared every cycle against a queue-based model of in-order retirement.
module tb_commit_vunit;
    localparam int NL = 16;
    localparam int NE = 8;
    localparam int W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commit_vunit_if #(.NUM_LANE(NL), .WIDTH_ENTRY(W)) bus ();

    commit_vunit #(
        .NUM_LANE    (NL),
        .NUM_ENTRY   (NE),
        .WIDTH_ENTRY (W)
`ifdef VCOMMIT_TIMEOUT_EN
       ,.TIMEOUT     (16)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: outstanding commands as a queue in issue order plus per-issue_no state.
    bit            m_v  [NE];
    logic [NL-1:0] m_lane [NE];
    logic [NL-1:0] m_cm [NE];
    int            order [$];
    bit            e_commit;
    int            e_commit_no;
    bit            e_err;

    function automatic void model_reset();
        for (int e = 0; e < NE; e++) begin
            m_v[e] = 1'b0; m_lane[e] = '0; m_cm[e] = '0;
        end
        order.delete();
        e_commit = 1'b0; e_commit_no = 0; e_err = 1'b0;
    endfunction

    function automatic void model_step();
        bit ret;
        bit iss;
        int h;
        h   = (order.size() > 0) ? order[0] : 0;
        ret = (order.size() > 0) && (m_cm[h] == m_lane[h]);
        iss = bus.issue_i && (order.size() < NE) && !m_v[bus.issue_no_i];
        if (bus.issue_i && !iss) e_err = 1'b1;
        for (int i = 0; i < NL; i++) begin
            if (bus.commit_lane_i[i]) begin
                int n;
                n = int'(bus.commit_no_i[i*W +: W]);
                if (m_v[n] && m_lane[n][i] && !m_cm[n][i]) m_cm[n][i] = 1'b1;
                else e_err = 1'b1;
            end
        end
        e_commit = ret;
        if (ret) begin
            void'(order.pop_front());
            m_v[h] = 1'b0; m_lane[h] = '0; m_cm[h] = '0;
            e_commit_no = h;
        end
        if (iss) begin
            order.push_back(int'(bus.issue_no_i));
            m_v[bus.issue_no_i]    = 1'b1;
            m_lane[bus.issue_no_i] = bus.en_lane_i;
            m_cm[bus.issue_no_i]   = '0;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("cmp_commit",    32'(bus.commit_o),    32'(e_commit));
            check("cmp_commit_no", 32'(bus.commit_no_o), 32'(e_commit_no));
            check("cmp_full",      32'(bus.full_o),      32'(order.size() == NE));
            check("cmp_empty",     32'(bus.empty_o),     32'(order.size() == 0));
            check("cmp_error",     32'(bus.error_o),     32'(e_err));
`ifndef VCOMMIT_TIMEOUT_EN
            check("cmp_timeout",    32'(bus.timeout_o),    32'd0);
            check("cmp_timeout_no", 32'(bus.timeout_no_o), 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.issue_i       = 1'b0;
        bus.issue_no_i    = '0;
        bus.en_lane_i     = '0;
        bus.commit_lane_i = '0;
        bus.commit_no_i   = '0;
    endtask

    task automatic issue(input int no, input logic [NL-1:0] en);
        bus.issue_i    = 1'b1;
        bus.issue_no_i = W'(no);
        bus.en_lane_i  = en;
    endtask

    task automatic lane_commit(input int lane, input int no);
        bus.commit_lane_i[lane]    = 1'b1;
        bus.commit_no_i[lane*W +: W] = W'(no);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clean_commits();
        for (int i = 0; i < NL; i++) begin
            for (int e = 0; e < NE; e++) begin
                if (m_v[e] && m_lane[e][i] && !m_cm[e][i]) begin
                    lane_commit(i, e);
                    break;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200 && !bus.empty_o; c++) begin
            idle();
            clean_commits();
            tick();
        end
        idle();
        check(name, 32'(bus.empty_o), 32'd1);
    endtask

    task automatic rand_cycle(input bit dirty);
        logic [NL-1:0] en;
        int free [$];
        int cand [$];
        idle();
        if ($urandom_range(0, 99) < 45) begin
            en = ($urandom_range(0, 3) == 0) ? '0 : (NL'($urandom) & NL'($urandom));
            if (dirty && $urandom_range(0, 9) == 0) begin
                issue(int'($urandom_range(0, NE-1)), en);
            end else begin
                free.delete();
                for (int e = 0; e < NE; e++) if (!m_v[e]) free.push_back(e);
                if (order.size() < NE && free.size() > 0)
                    issue(free[$urandom_range(0, free.size()-1)], en);
            end
        end
        for (int i = 0; i < NL; i++) begin
            if ($urandom_range(0, 99) < 35) begin
                cand.delete();
                for (int e = 0; e < NE; e++) if (m_v[e] && m_lane[e][i] && !m_cm[e][i]) cand.push_back(e);
                if (dirty && $urandom_range(0, 9) == 0) lane_commit(i, int'($urandom_range(0, NE-1)));
                else if (cand.size() > 0) lane_commit(i, cand[$urandom_range(0, cand.size()-1)]);
            end
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        do_reset();

        // Reset state
        check("rst_empty",   32'(bus.empty_o),   32'd1);
        check("rst_full",    32'(bus.full_o),    32'd0);
        check("rst_commit",  32'(bus.commit_o),  32'd0);
        check("rst_error",   32'(bus.error_o),   32'd0);
        check("rst_timeout", 32'(bus.timeout_o), 32'd0);

        // Four lanes complete issue_no 3 together; retire pulse two edges after the commit
        issue(3, 16'h000F);
        tick();
        idle();
        for (int i = 0; i < 4; i++) lane_commit(i, 3);
        tick();
        idle();
        check("t1_commit_early", 32'(bus.commit_o), 32'd0);
        tick();
        check("t1_commit",    32'(bus.commit_o),    32'd1);
        check("t1_commit_no", 32'(bus.commit_no_o), 32'd3);
        check("t1_empty",     32'(bus.empty_o),     32'd1);

        // Out-of-order lane commits still retire in issue order
        issue(5, 16'h0001); tick();
        issue(6, 16'h0001); tick();
        idle(); lane_commit(0, 6); tick();
        idle(); lane_commit(0, 5); tick();
        idle(); tick();
        check("t2_first",     32'(bus.commit_no_o), 32'd5);
        tick();
        check("t2_second",    32'(bus.commit_o),    32'd1);
        check("t2_second_no", 32'(bus.commit_no_o), 32'd6);
        check("t2_no_error",  32'(bus.error_o),     32'd0);
        tick();
        check("t2_idle",      32'(bus.commit_o),    32'd0);
        check("t2_hold_no",   32'(bus.commit_no_o), 32'd6);

        // Fill the table, overflow issue, and a same-cycle retire that does not admit an issue
        do_reset();
        for (int k = 0; k < NE; k++) begin
            issue(k, 16'h0001);
            tick();
        end
        idle();
        check("t3_full",  32'(bus.full_o),  32'd1);
        check("t3_noerr", 32'(bus.error_o), 32'd0);
        issue(3, 16'h0001); tick(); idle();
        check("t3_overflow_err", 32'(bus.error_o), 32'd1);
        lane_commit(0, 0); tick(); idle();
        issue(0, 16'h0002); tick(); idle();
        check("t3_retire",    32'(bus.commit_o),    32'd1);
        check("t3_retire_no", 32'(bus.commit_no_o), 32'd0);
        check("t3_not_full",  32'(bus.full_o),      32'd0);
        issue(0, 16'h0002); tick(); idle();
        check("t3_refull", 32'(bus.full_o), 32'd1);
        drain("t3_drain");

        // Lane commit protocol errors
        do_reset();
        lane_commit(2, 4); tick(); idle();
        check("t4_invalid_err", 32'(bus.error_o), 32'd1);
        do_reset();
        issue(4, 16'h0003); tick(); idle();
        lane_commit(2, 4); tick(); idle();
        check("t4_lane_err", 32'(bus.error_o), 32'd1);
        do_reset();
        issue(4, 16'h0003); tick(); idle();
        lane_commit(0, 4); tick(); idle();
        check("t4_ok", 32'(bus.error_o), 32'd0);
        lane_commit(0, 4); tick(); idle();
        check("t4_dup_err", 32'(bus.error_o), 32'd1);
        lane_commit(1, 4); tick(); idle();
        tick();
        check("t4_retire",    32'(bus.commit_o),    32'd1);
        check("t4_retire_no", 32'(bus.commit_no_o), 32'd4);

        // Empty lane mask retires on its own; reset with entries pending
        do_reset();
        issue(7, 16'h0000); tick(); idle();
        check("t5_early", 32'(bus.commit_o), 32'd0);
        tick();
        check("t5_commit",    32'(bus.commit_o),    32'd1);
        check("t5_commit_no", 32'(bus.commit_no_o), 32'd7);
        for (int k = 1; k <= 4; k++) begin
            issue(k, 16'h0001); tick();
        end
        idle();
        lane_commit(0, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_empty",  32'(bus.empty_o),     32'd1);
        check("t5_rst_commit", 32'(bus.commit_o),    32'd0);
        check("t5_rst_no",     32'(bus.commit_no_o), 32'd0);
        check("t5_rst_full",   32'(bus.full_o),      32'd0);
        idle();
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_no_commit", 32'(bus.commit_o), 32'd0);
        end

        // Head watchdog
        do_reset();
        issue(2, 16'h0001); tick(); idle();
`ifdef VCOMMIT_TIMEOUT_EN
        for (int k = 0; k < 10; k++) tick();
        check("t6_not_yet", 32'(bus.timeout_o), 32'd0);
        for (int k = 0; k < 30 && !bus.timeout_o; k++) tick();
        check("t6_timeout",    32'(bus.timeout_o),    32'd1);
        check("t6_timeout_no", 32'(bus.timeout_no_o), 32'd2);
`else
        for (int k = 0; k < 40; k++) tick();
        check("t6_timeout_off", 32'(bus.timeout_o), 32'd0);
`endif
        drain("t6_drain");

        // Random protocol-clean traffic, then traffic with injected violations
        do_reset();
        for (int c = 0; c < 400; c++) rand_cycle(1'b0);
        drain("rand_clean_drain");
        check("rand_clean_noerr", 32'(bus.error_o), 32'd0);
        for (int c = 0; c < 400; c++) rand_cycle(1'b1);
        drain("rand_dirty_drain");

        idle();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
